ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
Parametrised EX->MEM pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It decouples the execute stage from a memory stage that can stall, such as a multi-cycle data bus. A saturating counter of MEM-side backpressure cycles is provided for performance monitoring.

Parameters:
REG_ADDR_W, 5, destination register address width
DATA_W, 32, register/data width (wdata, reg2)
ADDR_W, 32, data memory address width
ALUOP_W, 8, aluop width
ALUOP_NONE, 0, aluop value presented when no valid instruction is held
SKID_EN, 1, 1 = two-entry skid buffer with registered ex_ready_o; 0 = single register with combinational ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush: discard all held entries
ex_valid_i  in  1  EX presents a valid instruction
ex_ready_o  out  1  pipe can accept this cycle
ex_wd_i  in  REG_ADDR_W  destination register
ex_wreg_i  in  1  register write enable
ex_wdata_i  in  DATA_W  ALU result
ex_aluop_i  in  ALUOP_W  operation code
ex_mem_addr_i  in  ADDR_W  load/store address
ex_reg2_i  in  DATA_W  store data
mem_valid_o  out  1  MEM-side entry valid
mem_ready_i  in  1  MEM consumes the head entry this cycle
mem_wd_o  out  REG_ADDR_W  head destination register
mem_wreg_o  out  1  head write enable, forced 0 when mem_valid_o=0
mem_wdata_o  out  DATA_W  head result
mem_aluop_o  out  ALUOP_W  head aluop, forced ALUOP_NONE when mem_valid_o=0
mem_mem_addr_o  out  ADDR_W  head address
mem_reg2_o  out  DATA_W  head store data
stall_cnt_o  out  CNT_W  cycles with mem_valid_o=1 and mem_ready_i=0, saturating

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, all payload registers 0, aluop registers ALUOP_NONE, stall_cnt_o 0. With SKID_EN=1, ex_ready_o=1 during and after reset.
- Handshake: accept = ex_valid_i & ex_ready_o; pop = mem_valid_o & mem_ready_i. The payload is captured only on accept. Head outputs stay stable while mem_valid_o=1 and mem_ready_i=0.
- Latency: one cycle from accept to mem_valid_o when empty. Order is strictly FIFO.
- SKID_EN=0:
  - ex_ready_o = ~mem_valid_o | mem_ready_i (combinational).
  - The head reloads on accept and clears its valid bit on a pop without accept.
- SKID_EN=1, state machine over {main_v, skid_v}:
  - EMPTY (0,0): accept -> ONE (load main).
  - ONE (1,0): accept&pop -> ONE (main<=input); accept&~pop -> TWO (skid<=input); pop&~accept -> EMPTY; otherwise hold.
  - TWO (1,1): pop -> ONE (main<=skid); accept is impossible.
  - ex_ready_o = ~skid_v, driven from a register with no combinational path from mem_ready_i.
- flush_i=1: at the next edge all valid bits clear (state EMPTY). Flush overrides a simultaneous accept and pop; the input is dropped and the pop is still taken by MEM that cycle. ex_ready_o is not gated by flush_i.
- Output qualification: mem_wreg_o=0 and mem_aluop_o=ALUOP_NONE when the head is invalid. Other outputs hold stale values (don't care).
- stall_cnt_o:
  - Increments by 1 on each cycle with mem_valid_o & ~mem_ready_i.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by reset.
- Reset mid-operation: all entries are lost immediately and outputs take reset values asynchronously. Deassertion is synchronised externally.

Test Plan:
- Streaming: mem_ready_i=1, ex_valid_i=1 for 8 cycles with ex_wdata_i=1..8 -> mem_wdata_o=1..8 one cycle later, mem_valid_o continuous, ex_ready_o=1 throughout, stall_cnt_o=0.
- Backpressure (SKID_EN=1): hold mem_ready_i=0 and push A=0x11, B=0x22 -> ex_ready_o drops to 0 the cycle after B is accepted. Releasing ready delivers A then B in order; stall_cnt_o equals the number of stalled cycles.
- Flush collision: in state TWO, assert flush_i with ex_valid_i=1 and mem_ready_i=1 -> next cycle mem_valid_o=0, mem_wreg_o=0, mem_aluop_o=ALUOP_NONE, ex_ready_o=1, and the input is not delivered.
- SKID_EN=0: mem_ready_i=0 with head valid -> ex_ready_o=0 the same cycle. With mem_ready_i=1 and ex_valid_i=1 -> the head is replaced by the new entry on the next edge with no bubble.
- Async reset mid-burst: drive rst low between clock edges while 2 entries are held -> outputs go to reset values before the next edge.
- Counter saturation: CNT_W=4, stall for 20 cycles -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register with valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating backpressure counter.
module ex_mem_pipe #(
   parameter int                   REG_ADDR_W = 5,
   parameter int                   DATA_W     = 32,
   parameter int                   ADDR_W     = 32,
   parameter int                   ALUOP_W    = 8,
   parameter logic [ALUOP_W-1:0]   ALUOP_NONE = '0,
   parameter int                   SKID_EN    = 1,
   parameter int                   CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [REG_ADDR_W-1:0] ex_wd_i,
   input  logic                  ex_wreg_i,
   input  logic [DATA_W-1:0]     ex_wdata_i,
   input  logic [ALUOP_W-1:0]    ex_aluop_i,
   input  logic [ADDR_W-1:0]     ex_mem_addr_i,
   input  logic [DATA_W-1:0]     ex_reg2_i,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [REG_ADDR_W-1:0] mem_wd_o,
   output logic                  mem_wreg_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic [ALUOP_W-1:0]    mem_aluop_o,
   output logic [ADDR_W-1:0]     mem_mem_addr_o,
   output logic [DATA_W-1:0]     mem_reg2_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);
   localparam int PW = REG_ADDR_W + 1 + DATA_W + ALUOP_W + ADDR_W + DATA_W;
   localparam logic [PW-1:0] RST_VAL = {{(REG_ADDR_W + 1 + DATA_W){1'b0}}, ALUOP_NONE, {(ADDR_W + DATA_W){1'b0}}};
   // Encoding makes bit0 the main valid and bit1 the skid valid, so ready comes straight off a flop.
   typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11} state_t;
   state_t st, nxt;
   logic ld_main, ld_skid, shift, accept, pop, main_v, skid_v, wreg_h;
   logic [PW-1:0] main_q, skid_q, in_w;
   logic [ALUOP_W-1:0] aluop_h;
   logic [CNT_W-1:0] cnt_q;
   assign main_v = st[0];
   assign skid_v = st[1];
   assign in_w = {ex_wd_i, ex_wreg_i, ex_wdata_i, ex_aluop_i, ex_mem_addr_i, ex_reg2_i};
   assign ex_ready_o = (SKID_EN != 0) ? ~skid_v : (~main_v | mem_ready_i);
   assign accept = ex_valid_i & ex_ready_o;
   assign pop = main_v & mem_ready_i;
   always_comb begin
      nxt = st;
      ld_main = 1'b0;
      ld_skid = 1'b0;
      shift = 1'b0;
      case (st)
         EMPTY: if (accept) begin nxt = ONE; ld_main = 1'b1; end
         ONE:
            if (accept & (pop | (SKID_EN == 0))) ld_main = 1'b1;
            else if (accept) begin nxt = TWO; ld_skid = 1'b1; end
            else if (pop) nxt = EMPTY;
         TWO: if (pop) begin nxt = ONE; shift = 1'b1; end
         default: nxt = EMPTY;
      endcase
      if (flush_i) begin
         nxt = EMPTY;
         ld_main = 1'b0;
         ld_skid = 1'b0;
         shift = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st <= EMPTY;
         main_q <= RST_VAL;
         skid_q <= RST_VAL;
         cnt_q <= '0;
      end else begin
         st <= nxt;
         if (ld_main) main_q <= in_w;
         else if (shift) main_q <= skid_q;
         if (ld_skid) skid_q <= in_w;
         if (main_v & ~mem_ready_i & ~&cnt_q) cnt_q <= cnt_q + 1'b1;
      end
   end
   assign {mem_wd_o, wreg_h, mem_wdata_o, aluop_h, mem_mem_addr_o, mem_reg2_o} = main_q;
   assign mem_valid_o = main_v;
   assign mem_wreg_o = main_v & wreg_h;
   assign mem_aluop_o = main_v ? aluop_h : ALUOP_NONE;
   assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: drives a skid-buffered (CNT_W=4) and a flat instance with shared
// stimulus and compares both against a small FIFO model every cycle.
module tb_ex_mem_pipe;
   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [7:0]  aluop;
      logic [31:0] addr;
      logic [31:0] reg2;
   } ent_t;
   logic clk = 1'b0, rst = 1'b0, flush = 1'b0, ex_valid = 1'b0, mem_ready = 1'b0;
   ent_t cur = '0;
   logic        rdy [2], mv [2], wreg_o [2];
   logic [4:0]  wd_o [2];
   logic [31:0] wdata_o [2], addr_o [2], reg2_o [2];
   logic [7:0]  aluop_o [2];
   logic [15:0] cnt_o [2];
   logic [3:0]  cnt_a;
   logic [15:0] cnt_b;
   ent_t m [2][2];
   int n [2];
   int cnt [2];
   int cmax [2] = '{15, 65535};
   int checks = 0, errors = 0;
   assign cnt_o[0] = {12'b0, cnt_a};
   assign cnt_o[1] = cnt_b;
   always #5 clk = ~clk;
   ex_mem_pipe #(.SKID_EN(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_ready_o(rdy[0]),
      .ex_wd_i(cur.wd), .ex_wreg_i(cur.wreg), .ex_wdata_i(cur.wdata), .ex_aluop_i(cur.aluop),
      .ex_mem_addr_i(cur.addr), .ex_reg2_i(cur.reg2), .mem_valid_o(mv[0]), .mem_ready_i(mem_ready),
      .mem_wd_o(wd_o[0]), .mem_wreg_o(wreg_o[0]), .mem_wdata_o(wdata_o[0]), .mem_aluop_o(aluop_o[0]),
      .mem_mem_addr_o(addr_o[0]), .mem_reg2_o(reg2_o[0]), .stall_cnt_o(cnt_a));
   ex_mem_pipe #(.SKID_EN(0)) u_flat (
      .clk(clk), .rst(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_ready_o(rdy[1]),
      .ex_wd_i(cur.wd), .ex_wreg_i(cur.wreg), .ex_wdata_i(cur.wdata), .ex_aluop_i(cur.aluop),
      .ex_mem_addr_i(cur.addr), .ex_reg2_i(cur.reg2), .mem_valid_o(mv[1]), .mem_ready_i(mem_ready),
      .mem_wd_o(wd_o[1]), .mem_wreg_o(wreg_o[1]), .mem_wdata_o(wdata_o[1]), .mem_aluop_o(aluop_o[1]),
      .mem_mem_addr_o(addr_o[1]), .mem_reg2_o(reg2_o[1]), .stall_cnt_o(cnt_b));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Skid instance holds up to two entries and its ready depends only on occupancy;
   // the flat instance holds one and may accept whenever the head leaves.
   function automatic logic exp_ready(input int k);
      return (k == 0) ? (n[0] < 2) : (n[1] == 0 || mem_ready);
   endfunction
   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("valid%0d", k), 64'(mv[k]), 64'(n[k] > 0));
         chk($sformatf("ready%0d", k), 64'(rdy[k]), 64'(exp_ready(k)));
         chk($sformatf("cnt%0d", k), 64'(cnt_o[k]), 64'(cnt[k]));
         chk($sformatf("wreg%0d", k), 64'(wreg_o[k]), 64'(n[k] > 0 ? m[k][0].wreg : 1'b0));
         chk($sformatf("aluop%0d", k), 64'(aluop_o[k]), 64'(n[k] > 0 ? m[k][0].aluop : 8'h00));
         if (n[k] > 0) begin
            chk($sformatf("wd%0d", k), 64'(wd_o[k]), 64'(m[k][0].wd));
            chk($sformatf("wdata%0d", k), 64'(wdata_o[k]), 64'(m[k][0].wdata));
            chk($sformatf("addr%0d", k), 64'(addr_o[k]), 64'(m[k][0].addr));
            chk($sformatf("reg2%0d", k), 64'(reg2_o[k]), 64'(m[k][0].reg2));
         end
      end
   endtask
   task automatic update();
      for (int k = 0; k < 2; k++) begin
         logic acc, pp;
         acc = ex_valid && exp_ready(k);
         pp = n[k] > 0 && mem_ready;
         if (n[k] > 0 && !mem_ready && cnt[k] < cmax[k]) cnt[k]++;
         if (flush) n[k] = 0;
         else begin
            if (pp) begin m[k][0] = m[k][1]; n[k]--; end
            if (acc) begin m[k][n[k]] = cur; n[k]++; end
         end
      end
   endtask
   task automatic model_reset();
      n = '{0, 0};
      cnt = '{0, 0};
   endtask
   // d < 0 leaves wdata random.
   task automatic step(input logic v, input logic r, input logic f, input int d);
      ex_valid = v;
      mem_ready = r;
      flush = f;
      cur.wd = 5'($urandom);
      cur.wreg = 1'($urandom);
      cur.wdata = (d < 0) ? $urandom : 32'(d);
      cur.aluop = 8'($urandom);
      cur.addr = $urandom;
      cur.reg2 = $urandom;
      #1 check_all();
      @(posedge clk);
      update();
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1 check_all();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask
   initial begin
      model_reset();
      @(negedge clk);
      do_reset();
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, i);
      step(1'b0, 1'b1, 1'b0, -1);
      step(1'b1, 1'b0, 1'b0, 32'h11);
      step(1'b1, 1'b0, 1'b0, 32'h22);
      step(1'b0, 1'b0, 1'b0, -1);
      chk("bp_ready", 64'(rdy[0]), 64'(0));
      step(1'b0, 1'b1, 1'b0, -1);
      step(1'b0, 1'b1, 1'b0, -1);
      step(1'b0, 1'b1, 1'b0, -1);
      step(1'b1, 1'b0, 1'b0, 32'hA);
      step(1'b1, 1'b0, 1'b0, 32'hB);
      step(1'b1, 1'b1, 1'b1, 32'hC);
      #1 chk("flush_valid", 64'(mv[0]), 64'(0));
      chk("flush_aluop", 64'(aluop_o[0]), 64'(0));
      chk("flush_ready", 64'(rdy[0]), 64'(1));
      step(1'b0, 1'b1, 1'b0, -1);
      step(1'b1, 1'b0, 1'b0, -1);
      step(1'b1, 1'b0, 1'b0, -1);
      #2 rst = 1'b0;
      model_reset();
      #1 check_all();
      chk("areset_valid", 64'(mv[0]), 64'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b0, -1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, -1);
      chk("sat", 64'(cnt_o[0]), 64'(15));
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0), -1);
      do_reset();
      step(1'b0, 1'b1, 1'b0, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
